// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the 5-stage MIPS core.
//   Tuse: how early the ID instruction needs an operand.
//   Tnew: how many cycles until a producer's result can be forwarded.
//   MULT_LAT_DEF / DIV_LAT_DEF: default multiply/divide unit busy latencies.
package pipe_pkg;

    localparam logic [1:0] TUSE_ID      = 2'd0;  // consumed in ID (beq/jr)
    localparam logic [1:0] TUSE_EX      = 2'd1;  // consumed in EX
    localparam logic [1:0] TUSE_NONE    = 2'd3;  // operand not read

    localparam logic [1:0] TNEW_LOAD_EX = 2'd2;  // load sitting in EX
    localparam logic [1:0] TNEW_ALU_EX  = 2'd1;  // ALU op sitting in EX

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/md_busy_tracker.sv
// Busy tracker for the shared multiply/divide unit.
// Loads the operation latency on an issue and counts down to zero.
//   clk, rst_n : core clock, asynchronous active-low reset
//   start      : issue pulse, sampled on the rising edge
//   is_div     : issued op is a divide (selects DIV_LAT over MULT_LAT)
//   busy       : counter nonzero
module md_busy_tracker #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // An issue never lands on a nonzero count (the stall logic holds new
    // mult/div back while busy), so the load simply overrides the decrement.
    always_comb begin
        count_next = count_reg;
        if (start) begin
            count_next = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (count_reg != '0) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Derived straight from the register so reset drops busy at once.
    assign busy = (count_reg != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls PC and IF/ID and bubbles ID/EX when
// forwarding cannot cover a dependency (Tuse < Tnew) or when the shared
// multiply/divide unit is busy. Issues MDU start pulses and keeps a
// saturating count of stall cycles.
//   Inputs : ID source registers and Tuse, EX/MEM destination info and Tnew,
//            ID mult/div and HI/LO-access flags.
//   Outputs: pc_en, ifid_en, idex_flush, md_start, md_busy, stall_cnt.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs_id,
    input  logic [4:0]        rt_id,
    input  logic [1:0]        tuse_rs_id,
    input  logic [1:0]        tuse_rt_id,
    input  logic              regwrite_ex,
    input  logic [4:0]        a3_ex,
    input  logic [1:0]        tnew_ex,
    input  logic              regwrite_mem,
    input  logic [4:0]        a3_mem,
    input  logic              memtoreg_mem,
    input  logic              md_op_id,
    input  logic              md_div_id,
    input  logic              md_use_id,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_flush,
    output logic              md_start,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    logic [4:0]        src  [2];
    logic [1:0]        tuse [2];
    logic [1:0]        src_stall;
    logic              stall_md;
    logic              stall;
    logic [PERF_W-1:0] stall_cnt_reg;

    assign src[0]  = rs_id;
    assign src[1]  = rt_id;
    assign tuse[0] = tuse_rs_id;
    assign tuse[1] = tuse_rt_id;

    // A load in MEM still has Tnew 1, so only ID-stage consumers wait on it.
    // $0 is hardwired and never creates a dependency.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_stall[gi] = (src[gi] != 5'd0) && (tuse[gi] != TUSE_NONE) &&
            ((regwrite_ex && (a3_ex == src[gi]) && (tuse[gi] < tnew_ex)) ||
             (regwrite_mem && memtoreg_mem && (a3_mem == src[gi]) &&
              (tuse[gi] < TUSE_EX)));
    end

    assign stall_md = (md_op_id || md_use_id) && md_busy;

    // Held low during reset so the front end runs freely while rst_n is low.
    assign stall = rst_n && ((|src_stall) || stall_md);

    assign pc_en      = ~stall;
    assign ifid_en    = ~stall;
    assign idex_flush = stall;
    assign md_start   = rst_n && md_op_id && ~stall;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (md_div_id),
        .busy   (md_busy)
    );

    // Saturating perf counter: pins at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != {PERF_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline scheduler for the 5-stage MIPS core; sits beside the forwarding unit and decides when forwarding alone is not enough.
- Compares operand need-time (Tuse) of the ID instruction against result-ready time (Tnew) of producers in EX/MEM. On a hazard it freezes PC and IF/ID and injects a bubble into ID/EX.
- Owns the shared multiply/divide unit (MDU). It issues start pulses, tracks busy with a latency counter, and stalls HI/LO users and new mult/div while the MDU is busy.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_LAT, 5, cycles MDU is busy after a mult issue
- DIV_LAT, 10, cycles MDU is busy after a div issue
- CNT_W, 4, busy counter width; must hold max(MULT_LAT, DIV_LAT)
- PERF_W, 32, stall counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs_id  in  5  rs of ID instruction
- rt_id  in  5  rt of ID instruction
- tuse_rs_id  in  2  0 = needed in ID (beq/jr), 1 = needed in EX, 3 = unused
- tuse_rt_id  in  2  same encoding for rt
- regwrite_ex  in  1  EX instruction writes the GPR file
- a3_ex  in  5  EX destination register
- tnew_ex  in  2  cycles until EX result is forwardable: load 2, ALU 1, link 0
- regwrite_mem  in  1  MEM instruction writes the GPR file
- a3_mem  in  5  MEM destination register
- memtoreg_mem  in  1  MEM instruction is a load (Tnew 1)
- md_op_id  in  1  ID holds mult/multu/div/divu
- md_div_id  in  1  the md op is a divide
- md_use_id  in  1  ID holds mfhi/mflo/mthi/mtlo
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID write enable
- idex_flush  out  1  load a bubble into ID/EX
- md_start  out  1  MDU start pulse, valid with the ID/EX capture edge
- md_busy  out  1  MDU busy counter nonzero
- stall_cnt  out  PERF_W  total stall cycles since reset

Behaviour:
- Reset (async, rst_n=0):
  - busy counter = 0; stall_cnt = 0.
  - Outputs while in reset: pc_en=1, ifid_en=1, idex_flush=0, md_start=0, md_busy=0.
- Data hazard (combinational):
  - For src in {rs, rt}: stall_rs/stall_rt when src_id != 0 and one of these holds:
    - regwrite_ex && a3_ex == src_id && tuse_src_id < tnew_ex
    - regwrite_mem && a3_mem == src_id && memtoreg_mem && tuse_src_id < 1
  - Tuse 3 never stalls.
- MDU hazard (combinational): stall_md = (md_op_id || md_use_id) && md_busy.
- Combined stall: stall = stall_rs | stall_rt | stall_md.
  - pc_en = ~stall; ifid_en = ~stall; idex_flush = stall.
  - Zero-cycle decision; no latency.
- MDU issue: md_start = md_op_id && ~stall (combinational).
  - On the same rising edge, the busy counter loads DIV_LAT if md_div_id, else MULT_LAT.
  - Otherwise a nonzero counter decrements by 1 per cycle and holds at 0.
  - md_busy = (counter != 0). It rises the cycle after issue and stays high for exactly LAT cycles.
- Back-to-back md ops: the second one stalls in ID until md_busy falls, then issues. A new issue never coincides with a nonzero counter.
- mfhi/mflo while busy: stalls for the remaining count. A reader in ID on the cycle the counter reaches 0 proceeds with no stall.
- Simultaneous data and MDU stall: a single stall; md_start is suppressed.
- stall_cnt increments every cycle stall=1. It saturates at all-ones and never wraps.
- Reset mid-operation: counter cleared immediately and md_busy drops asynchronously.
- Forwarding-mux selection stays in forward; this block never touches it.

Decomposition:
- Shared package pipe_pkg: Tuse/Tnew encodings (TUSE_ID=0, TUSE_EX=1, TUSE_NONE=3, TNEW_LOAD_EX=2, TNEW_ALU_EX=1), MULT_LAT/DIV_LAT defaults.
- One sub-module: md_busy_tracker (load/decrement counter, md_busy output).
- Hazard comparators stay inline.

Test Plan:
- lw $8 in EX (tnew 2); beq $8,$9 in ID (tuse 0) -> stall 2 cycles: pc_en=0, idex_flush=1 while lw is in EX and then MEM; released when lw reaches WB. stall_cnt=2.
- lw $8 in EX; add $3,$8,$0 in ID (tuse 1) -> exactly 1 stall cycle. Same case with a3_ex=0 -> no stall.
- add $8 in EX (tnew 1); jr $8 in ID (tuse 0) -> 1 stall cycle. addu consumer (tuse 1) -> no stall.
- mult issued (md_start=1 for one cycle); mflo reaches ID next cycle -> stalls 5 cycles, proceeds when counter=0. div -> 10 cycles.
- mult then div in consecutive instructions -> div held in ID 5 cycles; md_start pulses twice, 6 cycles apart; md_busy high for 5 then 10 cycles.
- Drive rst_n low mid-divide (counter=6) -> md_busy=0 and stall_cnt=0 immediately. Force a continuous stall for 2^PERF_W+3 cycles (PERF_W=4 build) -> stall_cnt stays at 15.
